// File: rtl/axi4l_reg_slave_if.sv
// rtl/axi4l_reg_slave_if.sv - AXI4-Lite bus bundle between a master and the register-bank slave
interface axi4l_reg_slave_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi4l_reg_slave.sv
// rtl/axi4l_reg_slave.sv - AXI4-Lite register bank slave with flat register output bus
// Optional read-only registers fed from ro_in when AXI4L_REG_SLAVE_RO_EN is defined.
module axi4l_reg_slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
`ifdef AXI4L_REG_SLAVE_RO_EN
  , parameter logic [NUM_REGS-1:0] RO_MASK = '0
`endif
) (
  input  logic                           aclk,
  input  logic                           areset,
  axi4l_reg_slave_if.slave               s_axi,
`ifdef AXI4L_REG_SLAVE_RO_EN
  input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in,
`endif
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFS  = $clog2(NB);
  localparam int IDXW = ADDR_WIDTH - OFS;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t               r_wstate;
  rstate_t               r_rstate;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_aw_held;
  logic                  r_w_held;
  logic [IDXW-1:0]       r_aw_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NB-1:0]         r_wstrb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_arready;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic [DATA_WIDTH-1:0] w_view [NUM_REGS];
  logic [IDXW-1:0]       w_ar_idx;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_rd_hit;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_wr_hit;
  logic                  w_wr_ro;
  logic                  w_unused;

  assign w_aw_hs  = r_awready & s_axi.awvalid;
  assign w_w_hs   = r_wready & s_axi.wvalid;
  assign w_ar_hs  = r_arready & s_axi.arvalid;
  assign w_ar_idx = s_axi.araddr[ADDR_WIDTH-1:OFS];
  assign w_unused = ^{s_axi.awprot, s_axi.arprot,
                      s_axi.awaddr[OFS-1:0], s_axi.araddr[OFS-1:0]};

  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_wready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;

  // Visible register contents: read-only slots (when enabled) mirror ro_in live.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_view[i] = r_regs[i];
`ifdef AXI4L_REG_SLAVE_RO_EN
      if (RO_MASK[i]) w_view[i] = ro_in[i*DATA_WIDTH +: DATA_WIDTH];
`endif
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = w_view[g];
  end

  always_comb begin
    w_rd_hit  = 1'b0;
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_ar_idx == IDXW'(i)) begin
        w_rd_hit  = 1'b1;
        w_rd_data = w_view[i];
      end
    end
  end

  always_comb begin
    w_wr_hit = 1'b0;
    w_wr_ro  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_aw_idx == IDXW'(i)) begin
        w_wr_hit = 1'b1;
`ifdef AXI4L_REG_SLAVE_RO_EN
        w_wr_ro  = RO_MASK[i];
`endif
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_idx  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VALUE;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (r_aw_held && r_w_held) begin
            if (w_wr_hit && !w_wr_ro) begin
              for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < NB; b++) begin
                  if (r_aw_idx == IDXW'(i) && r_wstrb[b])
                    r_regs[i][8*b +: 8] <= r_wdata[8*b +: 8];
                end
              end
            end
            r_bresp   <= !w_wr_hit ? RESP_DECERR : (w_wr_ro ? RESP_SLVERR : RESP_OKAY);
            r_bvalid  <= 1'b1;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_wstate  <= W_RESP;
          end else begin
            if (w_aw_hs) begin
              r_aw_idx  <= s_axi.awaddr[ADDR_WIDTH-1:OFS];
              r_aw_held <= 1'b1;
            end
            if (w_w_hs) begin
              r_wdata  <= s_axi.wdata;
              r_wstrb  <= s_axi.wstrb;
              r_w_held <= 1'b1;
            end
            r_awready <= !(r_aw_held || w_aw_hs);
            r_wready  <= !(r_w_held || w_w_hs);
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read data is captured on the AR edge, so it never sees a write committing later.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rd_data;
            r_rresp   <= w_rd_hit ? RESP_OKAY : RESP_DECERR;
            r_arready <= 1'b0;
            r_rstate  <= R_DATA;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi.rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4l_reg_slave.sv
// tb/tb_axi4l_reg_slave.sv - scoreboard bench for axi4l_reg_slave with directed vectors
`define CHK(n, a, e) chk(n, 64'(a), 64'(e))

module tb_axi4l_reg_slave;
  localparam logic [31:0] RV     = 32'h1234_5678;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  DECERR = 2'b11;

  logic         aclk = 1'b0;
  logic         areset;
  logic [511:0] reg_out;
  logic [31:0]  exp_regs [16];
  logic [1:0]   q_b [$];
  logic [33:0]  q_r [$];
  logic [1:0]   eb;
  logic [33:0]  er;
  logic         go;
  int           n_checks = 0;
  int           n_pass = 0;

  always #5 aclk = ~aclk;

  axi4l_reg_slave_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  axi4l_reg_slave #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_REGS(16), .RESET_VALUE(RV)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .s_axi(bus),
`ifdef AXI4L_REG_SLAVE_RO_EN
    .ro_in('0),
`endif
    .reg_out(reg_out)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_regs(input string name);
    logic [511:0] e;
    for (int i = 0; i < 16; i++) e[i*32 +: 32] = exp_regs[i];
    n_checks++;
    if (reg_out === e) n_pass++;
    else $display("FAIL %s: reg_out got 0x%0h, expected 0x%0h", name, reg_out, e);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drain();
    for (int t = 0; t < 20 && (q_b.size() + q_r.size()) != 0; t++) @(negedge aclk);
    `CHK("drain", q_b.size() + q_r.size(), 0);
    tick();
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] resp);
    logic ago, wgo;
    q_b.push_back(resp);
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    for (int t = 0; t < 20 && (bus.awvalid || bus.wvalid); t++) begin
      @(negedge aclk);
      ago = bus.awvalid && bus.awready;
      wgo = bus.wvalid && bus.wready;
      tick();
      if (ago) bus.awvalid = 1'b0;
      if (wgo) bus.wvalid = 1'b0;
    end
    `CHK("wr_accept", {bus.awvalid, bus.wvalid}, 2'b00);
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] d, input logic [1:0] resp);
    logic ago;
    q_r.push_back({resp, d});
    bus.araddr = a; bus.arvalid = 1'b1;
    for (int t = 0; t < 20 && bus.arvalid; t++) begin
      @(negedge aclk);
      ago = bus.arvalid && bus.arready;
      tick();
      if (ago) bus.arvalid = 1'b0;
    end
    `CHK("ar_accept", bus.arvalid, 0);
    `CHK("rvalid_after_ar", bus.rvalid, 1);
  endtask

  always @(negedge aclk) begin
    if (!areset && bus.bvalid && bus.bready) begin
      if (q_b.size() == 0) begin
        n_checks++;
        $display("FAIL b_unexpected: got bresp 0x%0h, expected no response", bus.bresp);
      end else begin
        eb = q_b.pop_front();
        `CHK("bresp", bus.bresp, eb);
      end
    end
    if (!areset && bus.rvalid && bus.rready) begin
      if (q_r.size() == 0) begin
        n_checks++;
        $display("FAIL r_unexpected: got rdata 0x%0h, expected no response", bus.rdata);
      end else begin
        er = q_r.pop_front();
        `CHK("rresp", bus.rresp, er[33:32]);
        `CHK("rdata", bus.rdata, er[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) exp_regs[i] = RV;
    areset = 1'b1;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
    repeat (3) tick();
    `CHK("rst_awready", bus.awready, 0);
    `CHK("rst_wready", bus.wready, 0);
    `CHK("rst_arready", bus.arready, 0);
    `CHK("rst_bvalid", bus.bvalid, 0);
    `CHK("rst_rvalid", bus.rvalid, 0);
    `CHK("rst_resp", {bus.bresp, bus.rresp}, 4'b0000);
    `CHK("rst_rdata", bus.rdata, 0);
    chk_regs("rst_regs");
    areset = 1'b0;
    tick(); tick();

    rd(12'h00C, RV, OKAY);
    drain();

    wr(12'h008, 32'hDEADBEEF, 4'b1111, OKAY);
    `CHK("bvalid_at_n", bus.bvalid, 0);
    tick();
    `CHK("bvalid_at_n1", bus.bvalid, 1);
    exp_regs[2] = 32'hDEADBEEF;
    `CHK("reg2_full", reg_out[95:64], 32'hDEADBEEF);
    drain();
    `CHK("awready_back", bus.awready, 1);
    rd(12'h008, 32'hDEADBEEF, OKAY);
    drain();

    q_b.push_back(OKAY);
    bus.wdata = 32'h0000_00AA; bus.wstrb = 4'b0001; bus.wvalid = 1'b1;
    for (int t = 0; t < 20 && bus.wvalid; t++) begin
      @(negedge aclk);
      go = bus.wvalid && bus.wready;
      tick();
      if (go) bus.wvalid = 1'b0;
    end
    `CHK("w_first_accept", bus.wvalid, 0);
    for (int k = 0; k < 3; k++) begin
      `CHK("wready_held_low", bus.wready, 0);
      `CHK("awready_open", bus.awready, 1);
      tick();
    end
    bus.awaddr = 12'h008; bus.awvalid = 1'b1;
    for (int t = 0; t < 20 && bus.awvalid; t++) begin
      @(negedge aclk);
      go = bus.awvalid && bus.awready;
      tick();
      if (go) bus.awvalid = 1'b0;
    end
    `CHK("aw_late_accept", bus.awvalid, 0);
    drain();
    exp_regs[2] = 32'hDEADBEAA;
    chk_regs("reg2_byte0");
    rd(12'h008, 32'hDEADBEAA, OKAY);
    drain();

    wr(12'h014, 32'hAABBCCDD, 4'b0110, OKAY);
    drain();
    exp_regs[5] = 32'h12BBCC78;
    chk_regs("reg5_mid_bytes");
    rd(12'h017, 32'h12BBCC78, OKAY);
    rd(12'h03C, RV, OKAY);
    drain();

    wr(12'h040, 32'h1111_1111, 4'b1111, DECERR);
    drain();
    chk_regs("decerr_no_change");
    rd(12'h040, 32'h0, DECERR);
    drain();

    bus.bready = 1'b0;
    wr(12'h010, 32'hCAFEF00D, 4'b1111, OKAY);
    for (int t = 0; t < 20 && !bus.bvalid; t++) tick();
    for (int k = 0; k < 5; k++) begin
      `CHK("bstall_bvalid", bus.bvalid, 1);
      `CHK("bstall_bresp", bus.bresp, OKAY);
      `CHK("bstall_readies", {bus.awready, bus.wready}, 2'b00);
      tick();
    end
    bus.bready = 1'b1;
    drain();
    exp_regs[4] = 32'hCAFEF00D;

    bus.rready = 1'b0;
    rd(12'h010, 32'hCAFEF00D, OKAY);
    for (int k = 0; k < 5; k++) begin
      `CHK("rstall_rvalid", bus.rvalid, 1);
      `CHK("rstall_rdata", bus.rdata, 32'hCAFEF00D);
      `CHK("rstall_rresp", bus.rresp, OKAY);
      `CHK("rstall_arready", bus.arready, 0);
      tick();
    end
    bus.rready = 1'b1;
    drain();

    bus.bready = 1'b0; bus.rready = 1'b0;
    wr(12'h004, 32'h0000_0055, 4'b1111, OKAY);
    rd(12'h008, 32'hDEADBEAA, OKAY);
    for (int t = 0; t < 20 && !bus.bvalid; t++) tick();
    `CHK("pre_rst_valids", {bus.bvalid, bus.rvalid}, 2'b11);
    areset = 1'b1;
    tick();
    q_b.delete(); q_r.delete();
    `CHK("midrst_valids", {bus.bvalid, bus.rvalid}, 2'b00);
    `CHK("midrst_readies", {bus.awready, bus.wready, bus.arready}, 3'b000);
    `CHK("midrst_rdata", bus.rdata, 0);
    areset = 1'b0; bus.bready = 1'b1; bus.rready = 1'b1;
    tick();
    `CHK("postrst_valids", {bus.bvalid, bus.rvalid}, 2'b00);
    for (int i = 0; i < 16; i++) exp_regs[i] = RV;
    chk_regs("postrst_regs");
    tick();
    wr(12'h004, 32'h0000_BEEF, 4'b0011, OKAY);
    drain();
    exp_regs[1] = 32'h1234BEEF;
    chk_regs("postrst_write");
    rd(12'h004, 32'h1234BEEF, OKAY);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/axi4l_reg_slave.md
Name: axi4l_reg_slave

Overview:
- AXI4-Lite slave register bank; the consumer that sits directly downstream of a master driving the team's `axi4l_if` bundle.
- Accepts write and read transactions and decodes them onto NUM_REGS word registers.
- Exposes register contents as a flat output bus for control logic.
- Returns AXI responses using the `axi4l_pkg` encoding: OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.

Parameters:
- ADDR_WIDTH, 12, byte-address width of awaddr/araddr.
- DATA_WIDTH, 32, data width; legal values 32 or 64.
- NUM_REGS, 16, number of registers; must satisfy 1 <= NUM_REGS <= 2^(ADDR_WIDTH-OFS).
- RESET_VALUE, 0, value loaded into every register at reset (DATA_WIDTH bits).

Ports:
- aclk  in  1  clock; all logic on the rising edge
- areset  in  1  synchronous reset, active-high
- awaddr  in  ADDR_WIDTH  write address
- awprot  in  3  ignored
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  byte strobes
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- araddr  in  ADDR_WIDTH  read address
- arprot  in  3  ignored
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  read response
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- reg_out  out  NUM_REGS*DATA_WIDTH  register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset (already decided): single clock aclk; reset areset is synchronous and active-high.
  - While areset=1: all outputs 0 (awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata).
  - Every register loads RESET_VALUE.
  - Both FSMs return to IDLE.
  - An in-flight transaction is dropped silently.
- Address decode:
  - OFS = log2(DATA_WIDTH/8).
  - Register index = addr[ADDR_WIDTH-1:OFS]; addr[OFS-1:0] is ignored.
  - Index >= NUM_REGS gives response DECERR.
- Write FSM, states W_IDLE and W_RESP:
  - W_IDLE: awready = !aw_held; wready = !w_held.
  - An AW handshake latches awaddr and sets aw_held. A W handshake latches wdata/wstrb and sets w_held.
  - AW and W may arrive in either order or in the same cycle.
  - On the edge where both are held (including both handshakes on the same edge), the write commits on the next edge:
    - each byte b of the target register with wstrb[b]=1 takes wdata byte b;
    - bytes with strobe 0 are unchanged;
    - a DECERR write modifies nothing.
  - The FSM then enters W_RESP with bvalid=1 and bresp = OKAY or DECERR. aw_held and w_held clear.
  - W_RESP: awready=wready=0. bvalid stays high and bresp stays stable until bready=1; then return to W_IDLE.
  - Latency: AW and W handshake at edge N, register updated at N+1, bvalid=1 from N+1. With bready held high, awready is back high at N+2.
- Read FSM, states R_IDLE and R_DATA:
  - R_IDLE: arready=1.
  - An AR handshake at edge N gives rvalid=1 from N+1.
    - rdata = register value as of edge N, i.e. before any write committing at N+1.
    - rresp = OKAY, or DECERR with rdata=0.
  - R_DATA: arready=0. rvalid, rdata and rresp stay stable until rready=1; then return to R_IDLE.
  - Back-to-back throughput: one read per 2 cycles.
- Read and write channels are fully independent. A read and a write to the same register in flight concurrently is legal; read ordering follows the rule above.
- valid is never withdrawn by the slave once asserted. No combinational path exists from any input to any ready/valid output.
- SLVERR is never generated in the base configuration.

Optional Feature:
- Macro AXI4L_REG_SLAVE_RO_EN.
- Defined:
  - adds parameter RO_MASK (NUM_REGS bits, default 0) and input ro_in (NUM_REGS*DATA_WIDTH);
  - registers with RO_MASK[i]=1 read the live ro_in slice and are not writable;
  - writes to them return SLVERR and change nothing; reg_out shows ro_in for those registers.
- Undefined: no RO_MASK or ro_in; every in-range register is read/write.

Test Plan:
- Reset then read index 3 (araddr=0x00C) -> rvalid=1 the cycle after AR handshake, rdata=RESET_VALUE, rresp=OKAY.
- AW=0x008 and W=0xDEADBEEF with wstrb=4'b1111 in the same cycle -> bvalid next cycle with bresp=OKAY; reg_out[95:64]=0xDEADBEEF; readback matches.
- W (0x000000AA, wstrb=4'b0001) 3 cycles before AW=0x008 -> wready low after the W handshake until response; reg2 becomes 0xDEADBEAA.
- Write to 0x040 (index 16, NUM_REGS=16) -> bresp=DECERR, no register changes; read 0x040 -> rresp=DECERR, rdata=0.
- bready held low 5 cycles -> bvalid and bresp stable, awready=wready=0 throughout; same for rvalid/rdata with rready low.
- areset pulsed while in W_RESP and R_DATA -> next cycle bvalid=rvalid=0, all regs=RESET_VALUE; a new write completes normally.
